itrace_retire_scheduler: RTL and testbench

ITRACE_RETIRE_SCHEDULER -- requirements
Module: itrace_retire_scheduler

---
 rtl/itrace_retire_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_itrace_retire_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itrace_retire_scheduler.sv
// itrace_retire_scheduler
// -----------------------
// Buffers retirement groups from the core and presents their retired lanes
// to the instruction trace encoder one lane per cycle.
//
// Each accepted group is stored in a circular FIFO of Depth entries, together
// with a pending-lane mask. The head entry emits its lowest pending lane. The
// head pops once its last pending lane is accepted. Groups that retire nothing
// are discarded without being stored.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   flush_i             synchronous clear of all buffered groups
//   valid_i / ready_o   group input handshake; drop_o pulses on a refused offer
//   iretire_i .. iaddr_i   per-lane retirement fields
//   cause_i, tval_i, priv_i   group-shared trap and privilege info
//   valid_o / ready_i   lane output handshake towards the encoder
//   iretire_o .. priv_o    the selected lane with the head group's shared fields
//   count_o             number of buffered groups

package mure_pkg;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned ITYPE_LEN     = 3;
  localparam int unsigned ILASTSIZE_LEN = 1;
  localparam int unsigned CAUSE_LEN     = 5;
  localparam int unsigned PRIV_LEN      = 2;
endpackage

module itrace_retire_scheduler
  import mure_pkg::*;
#(
  parameter int unsigned NrRetiredInstr = 2,
  parameter int unsigned Depth          = 4
) (
  input  logic                                          clk_i,
  input  logic                                          rst_i,
  input  logic                                          flush_i,
  input  logic                                          valid_i,
  output logic                                          ready_o,
  input  logic [NrRetiredInstr-1:0]                     iretire_i,
  input  logic [NrRetiredInstr-1:0][ILASTSIZE_LEN-1:0]  ilastsize_i,
  input  logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0]      itype_i,
  input  logic [NrRetiredInstr-1:0][XLEN-1:0]           iaddr_i,
  input  logic [CAUSE_LEN-1:0]                          cause_i,
  input  logic [XLEN-1:0]                               tval_i,
  input  logic [PRIV_LEN-1:0]                           priv_i,
  output logic                                          valid_o,
  input  logic                                          ready_i,
  output logic                                          iretire_o,
  output logic [ILASTSIZE_LEN-1:0]                      ilastsize_o,
  output logic [ITYPE_LEN-1:0]                          itype_o,
  output logic [XLEN-1:0]                               iaddr_o,
  output logic [CAUSE_LEN-1:0]                          cause_o,
  output logic [XLEN-1:0]                               tval_o,
  output logic [PRIV_LEN-1:0]                           priv_o,
  output logic [$clog2(Depth):0]                        count_o,
  output logic                                          drop_o
);

  localparam int unsigned PtrW  = $clog2(Depth);
  localparam int unsigned CntW  = $clog2(Depth) + 1;
  localparam int unsigned LaneW = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q;

  // Group storage. Only the pending masks carry reset; payload entries are
  // only ever read while their mask marks them as live.
  logic [NrRetiredInstr-1:0]                     mask_q      [Depth];
  logic [NrRetiredInstr-1:0][ILASTSIZE_LEN-1:0]  ilastsize_q [Depth];
  logic [NrRetiredInstr-1:0][ITYPE_LEN-1:0]      itype_q     [Depth];
  logic [NrRetiredInstr-1:0][XLEN-1:0]           iaddr_q     [Depth];
  logic [CAUSE_LEN-1:0]                          cause_q     [Depth];
  logic [XLEN-1:0]                               tval_q      [Depth];
  logic [PRIV_LEN-1:0]                           priv_q      [Depth];

  logic                      store, fire, pop, head_last;
  logic [NrRetiredInstr-1:0] head_mask, sel_onehot;
  logic [LaneW-1:0]          sel_idx;

  // ready_o looks only at the registered count, so a pop in the same cycle
  // never frees a slot for an incoming group.
  assign ready_o = (count_q < CntW'(Depth));
  assign valid_o = (state_q == DRAIN);
  assign count_o = count_q;

  // Reset and flush swallow the inputs of their cycle entirely.
  assign store  = valid_i && ready_o && (|iretire_i) && !flush_i && !rst_i;
  assign drop_o = valid_i && !ready_o && !flush_i && !rst_i;
  assign fire   = valid_o && ready_i && !flush_i && !rst_i;

  assign head_mask  = mask_q[rd_ptr_q];
  // Two's-complement trick isolates the lowest set bit of the pending mask.
  assign sel_onehot = head_mask & (~head_mask + 1'b1);
  assign head_last  = ((head_mask & ~sel_onehot) == '0);
  assign pop        = fire && head_last;

  always_comb begin
    sel_idx = '0;
    for (int i = NrRetiredInstr - 1; i >= 0; i--) begin
      if (head_mask[i]) sel_idx = LaneW'(i);
    end
  end

  // FSM next state: DRAIN is left only when the last group pops and nothing
  // new arrives in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (store) state_d = DRAIN;
      DRAIN:   if (pop && (count_q == CntW'(1)) && !store) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (store) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({store, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: ;
      endcase
    end
  end

  // A store and a lane acceptance never target the same entry: with
  // 0 < count < Depth the two pointers always differ.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int i = 0; i < int'(Depth); i++) mask_q[i] <= '0;
    end else begin
      if (fire)  mask_q[rd_ptr_q] <= head_mask & ~sel_onehot;
      if (store) mask_q[wr_ptr_q] <= iretire_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store) begin
      ilastsize_q[wr_ptr_q] <= ilastsize_i;
      itype_q[wr_ptr_q]     <= itype_i;
      iaddr_q[wr_ptr_q]     <= iaddr_i;
      cause_q[wr_ptr_q]     <= cause_i;
      tval_q[wr_ptr_q]      <= tval_i;
      priv_q[wr_ptr_q]      <= priv_i;
    end
  end

  // Data outputs are forced to zero whenever no lane is presented.
  always_comb begin
    iretire_o   = 1'b0;
    ilastsize_o = '0;
    itype_o     = '0;
    iaddr_o     = '0;
    cause_o     = '0;
    tval_o      = '0;
    priv_o      = '0;
    if (valid_o) begin
      iretire_o   = 1'b1;
      ilastsize_o = ilastsize_q[rd_ptr_q][sel_idx];
      itype_o     = itype_q[rd_ptr_q][sel_idx];
      iaddr_o     = iaddr_q[rd_ptr_q][sel_idx];
      cause_o     = cause_q[rd_ptr_q];
      tval_o      = tval_q[rd_ptr_q];
      priv_o      = priv_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_itrace_retire_scheduler.sv
// tb_itrace_retire_scheduler
// --------------------------
// Self-checking bench for itrace_retire_scheduler. A queue-of-groups model
// tracks what the scheduler must hold. A negedge process compares every
// output against that model on each cycle. Directed scenarios add literal
// expectations, and a randomized phase exercises back-pressure, zero-retire
// groups, flush and reset.

module tb_itrace_retire_scheduler;
  import mure_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 4;

  logic                                clk_i = 1'b0;
  logic                                rst_i, flush_i, valid_i, ready_i;
  logic                                ready_o, valid_o, iretire_o, drop_o;
  logic [NR-1:0]                       iretire_i;
  logic [NR-1:0][ILASTSIZE_LEN-1:0]    ilastsize_i;
  logic [NR-1:0][ITYPE_LEN-1:0]        itype_i;
  logic [NR-1:0][XLEN-1:0]             iaddr_i;
  logic [CAUSE_LEN-1:0]                cause_i, cause_o;
  logic [XLEN-1:0]                     tval_i, tval_o, iaddr_o;
  logic [PRIV_LEN-1:0]                 priv_i, priv_o;
  logic [ILASTSIZE_LEN-1:0]            ilastsize_o;
  logic [ITYPE_LEN-1:0]                itype_o;
  logic [$clog2(DEPTH):0]              count_o;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  itrace_retire_scheduler #(.NrRetiredInstr(NR), .Depth(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .iretire_i(iretire_i), .ilastsize_i(ilastsize_i), .itype_i(itype_i),
    .iaddr_i(iaddr_i), .cause_i(cause_i), .tval_i(tval_i), .priv_i(priv_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .itype_o(itype_o),
    .iaddr_o(iaddr_o), .cause_o(cause_o), .tval_o(tval_o), .priv_o(priv_o),
    .count_o(count_o), .drop_o(drop_o)
  );

  always #5 clk_i = ~clk_i;

  // Model: a queue of buffered groups, each with its still-pending lanes.
  typedef struct packed {
    logic [NR-1:0]                    mask;
    logic [NR-1:0][ILASTSIZE_LEN-1:0] ils;
    logic [NR-1:0][ITYPE_LEN-1:0]     ity;
    logic [NR-1:0][XLEN-1:0]          addr;
    logic [CAUSE_LEN-1:0]             cause;
    logic [XLEN-1:0]                  tval;
    logic [PRIV_LEN-1:0]              priv;
  } grp_t;

  grp_t mq[$];

  function automatic int lowLane(input logic [NR-1:0] m);
    for (int i = 0; i < NR; i++) if (m[i]) return i;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge, from the inputs of that cycle.
  grp_t m_h, m_g;
  int   m_l;
  bit   m_acc;
  always @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      mq.delete();
    end else begin
      m_acc = valid_i && (mq.size() < DEPTH);
      if (mq.size() > 0 && ready_i) begin
        m_h = mq[0];
        m_l = lowLane(m_h.mask);
        m_h.mask[m_l] = 1'b0;
        if (m_h.mask == '0) void'(mq.pop_front());
        else mq[0] = m_h;
      end
      if (m_acc && iretire_i != '0) begin
        m_g.mask = iretire_i; m_g.ils = ilastsize_i; m_g.ity = itype_i;
        m_g.addr = iaddr_i; m_g.cause = cause_i; m_g.tval = tval_i; m_g.priv = priv_i;
        mq.push_back(m_g);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  grp_t c_h;
  int   c_l;
  always @(negedge clk_i) begin
    if (cmp_en) begin
      checkOutput("valid_o", valid_o, mq.size() != 0);
      checkOutput("ready_o", ready_o, mq.size() < DEPTH);
      checkOutput("count_o", count_o, mq.size());
      checkOutput("drop_o", drop_o, valid_i && (mq.size() >= DEPTH) && !flush_i && !rst_i);
      if (mq.size() != 0) begin
        c_h = mq[0];
        c_l = lowLane(c_h.mask);
        checkOutput("iretire_o", iretire_o, 1'b1);
        checkOutput("ilastsize_o", ilastsize_o, c_h.ils[c_l]);
        checkOutput("itype_o", itype_o, c_h.ity[c_l]);
        checkOutput("iaddr_o", iaddr_o, c_h.addr[c_l]);
        checkOutput("cause_o", cause_o, c_h.cause);
        checkOutput("tval_o", tval_o, c_h.tval);
        checkOutput("priv_o", priv_o, c_h.priv);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic driveGroup(input logic [NR-1:0] ret, input logic [XLEN-1:0] a0, input logic [XLEN-1:0] a1,
                            input logic [ITYPE_LEN-1:0] t0, input logic [ITYPE_LEN-1:0] t1,
                            input logic [ILASTSIZE_LEN-1:0] l0, input logic [ILASTSIZE_LEN-1:0] l1);
    valid_i     = 1'b1;
    iretire_i   = ret;
    iaddr_i[0]  = a0;   iaddr_i[1]  = a1;
    itype_i[0]  = t0;   itype_i[1]  = t1;
    ilastsize_i[0] = l0; ilastsize_i[1] = l1;
    cause_i = CAUSE_LEN'($urandom);
    tval_i  = $urandom;
    priv_i  = PRIV_LEN'($urandom);
  endtask

  // Randomized traffic; ready_i bias shifts every 64 cycles so the FIFO
  // spends time both nearly empty and full.
  task automatic applyStimulus(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      driveGroup(NR'($urandom), $urandom, $urandom, ITYPE_LEN'($urandom), ITYPE_LEN'($urandom),
                 ILASTSIZE_LEN'($urandom), ILASTSIZE_LEN'($urandom));
      valid_i = ($urandom_range(0, 2) != 0);
      ready_i = ((c / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush_i = ($urandom_range(0, 49) == 0);
      rst_i   = ($urandom_range(0, 96) == 0);
      tick();
    end
    valid_i = 1'b0; flush_i = 1'b0; rst_i = 1'b0; ready_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    iretire_i = '0; ilastsize_i = '0; itype_i = '0; iaddr_i = '0;
    cause_i = '0; tval_i = '0; priv_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i  = 1'b0;
    cmp_en = 1'b1;

    // Reset state.
    @(negedge clk_i);
    checkOutput("rst_valid", valid_o, 1'b0);
    checkOutput("rst_ready", ready_o, 1'b1);
    checkOutput("rst_count", count_o, 0);
    checkOutput("rst_drop", drop_o, 1'b0);
    checkOutput("rst_data", {iretire_o, ilastsize_o, itype_o, cause_o, priv_o}, 0);
    checkOutput("rst_addr", {iaddr_o, tval_o}, 0);

    // Two-lane group drains in ascending lane order.
    tick();
    driveGroup(2'b11, 32'h1000, 32'h1004, 3'd0, 3'd0, 1'b0, 1'b0);
    tick();
    valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("g11_lane0", iaddr_o, 32'h1000);
    checkOutput("g11_cnt", count_o, 1);
    tick();
    @(negedge clk_i);
    checkOutput("g11_lane1", iaddr_o, 32'h1004);
    tick();
    @(negedge clk_i);
    checkOutput("g11_done_valid", valid_o, 1'b0);
    checkOutput("g11_done_cnt", count_o, 0);

    // Only lane 1 retires.
    driveGroup(2'b10, 32'h2222, 32'h2002, 3'd1, 3'd5, 1'b0, 1'b1);
    tick();
    valid_i = 1'b0;
    @(negedge clk_i);
    checkOutput("g10_addr", iaddr_o, 32'h2002);
    checkOutput("g10_itype", itype_o, 3'd5);
    checkOutput("g10_ilast", ilastsize_o, 1'b1);
    tick();
    @(negedge clk_i);
    checkOutput("g10_single", valid_o, 1'b0);

    // Overfill under back-pressure, then drain 8 lanes in order.
    ready_i = 1'b0;
    for (int g = 0; g < 4; g++) begin
      driveGroup(2'b11, 32'h3000 + 32'(g * 16), 32'h3004 + 32'(g * 16), 3'd2, 3'd3, 1'b1, 1'b0);
      tick();
    end
    driveGroup(2'b11, 32'h3F00, 32'h3F04, 3'd2, 3'd3, 1'b1, 1'b0);
    @(negedge clk_i);
    checkOutput("full_cnt", count_o, 4);
    checkOutput("full_ready", ready_o, 1'b0);
    checkOutput("full_drop", drop_o, 1'b1);
    tick();
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      checkOutput("drain_valid", valid_o, 1'b1);
      checkOutput("drain_addr", iaddr_o, 32'h3000 + 32'((k / 2) * 16 + (k % 2) * 4));
      tick();
    end
    @(negedge clk_i);
    checkOutput("drain_end", valid_o, 1'b0);

    // Held output under ready_i low.
    ready_i = 1'b0;
    driveGroup(2'b11, 32'h4000, 32'h4004, 3'd4, 3'd6, 1'b0, 1'b1);
    tick();
    valid_i = 1'b0;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk_i);
      checkOutput("hold_addr", iaddr_o, 32'h4000);
      checkOutput("hold_valid", valid_o, 1'b1);
      tick();
    end
    ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("hold_rel0", iaddr_o, 32'h4000);
    tick();
    @(negedge clk_i);
    checkOutput("hold_rel1", iaddr_o, 32'h4004);
    tick();
    @(negedge clk_i);
    checkOutput("hold_end", valid_o, 1'b0);

    // Streaming single-lane groups wrap the pointers without dropping.
    ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      driveGroup(2'b01, 32'h5000 + 32'(c * 4), 32'hDEAD, 3'd7, 3'd0, 1'b1, 1'b0);
      @(negedge clk_i);
      checkOutput("stream_cnt_le1", count_o <= 1, 1'b1);
      checkOutput("stream_drop", drop_o, 1'b0);
      if (c > 0) checkOutput("stream_addr", iaddr_o, 32'h5000 + 32'((c - 1) * 4));
      tick();
    end
    valid_i = 1'b0;
    tick();
    tick();

    // Flush, then reset, mid-group with two groups buffered.
    for (int pass = 0; pass < 2; pass++) begin
      ready_i = 1'b0;
      driveGroup(2'b11, 32'h6000, 32'h6004, 3'd1, 3'd1, 1'b0, 1'b0);
      tick();
      driveGroup(2'b11, 32'h6010, 32'h6014, 3'd1, 3'd1, 1'b0, 1'b0);
      tick();
      valid_i = 1'b0;
      ready_i = 1'b1;
      tick();
      if (pass == 0) flush_i = 1'b1; else rst_i = 1'b1;
      tick();
      flush_i = 1'b0; rst_i = 1'b0;
      @(negedge clk_i);
      checkOutput("clr_valid", valid_o, 1'b0);
      checkOutput("clr_cnt", count_o, 0);
      driveGroup(2'b11, 32'h6100, 32'h6104, 3'd2, 3'd2, 1'b0, 1'b0);
      tick();
      valid_i = 1'b0;
      @(negedge clk_i);
      checkOutput("after_clr0", iaddr_o, 32'h6100);
      tick();
      @(negedge clk_i);
      checkOutput("after_clr1", iaddr_o, 32'h6104);
      tick();
      @(negedge clk_i);
      checkOutput("after_clr_end", valid_o, 1'b0);
    end

    applyStimulus(800);
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
